// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Sequential front-end for an external 5-bit combinational ALU. It holds a
// 4 x 5-bit operand register file and accepts commands over a valid/ready
// handshake. Each accepted command does three things:
//   - presents registered S/A/B to the ALU,
//   - captures the ALU result one cycle later and writes it back to the
//     destination register,
//   - reports the result with a one-cycle strobe.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_op/src_a/src_b  ALU select and operand register indices
//   cmd_dst             writeback register index
//   ld_en/addr/data     direct register load (any state)
//   alu_s/a/b           registered ALU inputs
//   alu_y               ALU result
//   res_valid/res_data  result strobe and held result
//   op_count            completed-operation counter (wraps)
//   rd_addr/rd_data     combinational debug read port
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_src_a,
  input  logic [1:0] cmd_src_b,
  input  logic [1:0] cmd_dst,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [4:0] ld_data,
  output logic [3:0] alu_s,
  output logic [4:0] alu_a,
  output logic [4:0] alu_b,
  input  logic [4:0] alu_y,
  output logic       res_valid,
  output logic [4:0] res_data,
  output logic [7:0] op_count,
  input  logic [1:0] rd_addr,
  output logic [4:0] rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0][4:0] regs_q, regs_d;
  logic [1:0]      dst_q, dst_d;
  logic [3:0]      alu_s_q, alu_s_d;
  logic [4:0]      alu_a_q, alu_a_d;
  logic [4:0]      alu_b_q, alu_b_d;
  logic [4:0]      res_data_q, res_data_d;
  logic            res_valid_q, res_valid_d;
  logic [7:0]      op_count_q, op_count_d;

  logic accept_s;
  logic issue_s;
  logic ld_we_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake and phase qualifiers
  always_comb begin
    // Gated by rst_n so the requester never sees ready while reset is held.
    cmd_ready = rst_n && (state_q == ST_IDLE);
    accept_s  = (state_q == ST_IDLE) && cmd_valid;
    issue_s   = (state_q == ST_ISSUE);
    // A load colliding with the writeback target is dropped.
    ld_we_s   = ld_en && !(issue_s && (ld_addr == dst_q));
  end

  // Datapath next values: register file, ALU operands, result, counter
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = (issue_s && (dst_q == 2'(i))) ? alu_y   :
                  (ld_we_s && (ld_addr == 2'(i))) ? ld_data :
                  regs_q[i];
    end
    // Operands read regs_q, i.e. contents before any same-edge load.
    dst_d       = accept_s ? cmd_dst           : dst_q;
    alu_s_d     = accept_s ? cmd_op            : alu_s_q;
    alu_a_d     = accept_s ? regs_q[cmd_src_a] : alu_a_q;
    alu_b_d     = accept_s ? regs_q[cmd_src_b] : alu_b_q;
    res_data_d  = issue_s  ? alu_y             : res_data_q;
    op_count_d  = issue_s  ? (op_count_q + 8'd1) : op_count_q;
    res_valid_d = issue_s;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q      <= 20'd0;
      dst_q       <= 2'd0;
      alu_s_q     <= 4'd0;
      alu_a_q     <= 5'd0;
      alu_b_q     <= 5'd0;
      res_data_q  <= 5'd0;
      res_valid_q <= 1'b0;
      op_count_q  <= 8'd0;
    end else begin
      regs_q      <= regs_d;
      dst_q       <= dst_d;
      alu_s_q     <= alu_s_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_s     = alu_s_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign op_count  = op_count_q;
  assign rd_data   = regs_q[rd_addr];

endmodule
